// File: rtl/gray_serializer.sv
// Register file with Gray encode/decode on read; the converted word is returned
// in parallel on dataout and streamed MSB-first over an LW-bit serial port.
module gray_serializer #(
  parameter int DW = 32,
  parameter int AW = 4,
  parameter int LW = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req,
  input  logic          rw,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] datain,
  input  logic          mode,
  output logic          ready,
  output logic [DW-1:0] dataout,
  output logic          dout_valid,
  output logic [LW-1:0] ss,
  output logic          ss_valid,
  output logic          ss_last,
  output logic          dbg_state
);

  localparam int BEATS = DW / LW;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t        state, state_nxt;
  logic [DW-1:0] rf [2**AW];
  logic [DW-1:0] shreg;
  logic [CW-1:0] cnt;
  logic [DW-1:0] conv;
  logic          accept, accept_rd, accept_wr, last_beat;

  function automatic logic [DW-1:0] bin2gray(input logic [DW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [DW-1:0] gray2bin(input logic [DW-1:0] g);
    logic [DW-1:0] b;
    b[DW-1] = g[DW-1];
    for (int i = DW - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  // Handshake: a command transfers on a rising edge with req=1 and ready=1;
  // ready is high only in IDLE, and req seen while busy is dropped, not queued.
  assign ready     = (state == IDLE);
  assign accept    = req && ready;
  assign accept_rd = accept && !rw;
  assign accept_wr = accept && rw;
  assign last_beat = (cnt == CW'(BEATS - 1));
  assign conv      = mode ? gray2bin(rf[addr]) : bin2gray(rf[addr]);
  assign dbg_state = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ss        = '0;
    ss_valid  = 1'b0;
    ss_last   = 1'b0;
    case (state)
      IDLE: begin
        if (accept_rd) state_nxt = SHIFT;
      end
      SHIFT: begin
        ss       = shreg[DW-1 -: LW];
        ss_valid = 1'b1;
        ss_last  = last_beat;
        if (last_beat) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The converted word is captured at acceptance, so later addr/mode changes
  // cannot disturb the word in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg      <= '0;
      cnt        <= '0;
      dataout    <= '0;
      dout_valid <= 1'b0;
    end else begin
      dout_valid <= 1'b0;
      if (accept_rd) begin
        shreg      <= conv;
        cnt        <= '0;
        dataout    <= conv;
        dout_valid <= 1'b1;
      end else if (state == SHIFT) begin
        shreg <= shreg << LW;
        cnt   <= last_beat ? '0 : cnt + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 2**AW; i++) rf[i] <= '0;
    end else if (accept_wr) begin
      rf[addr] <= datain;
    end
  end

endmodule
